// File: rtl/ram_stream_tx_pkg.sv
// ram_stream_tx_pkg: control-word field layout and transmitter state encodings
package ram_stream_tx_pkg;
  localparam int CTRL_LEN_LSB = 0;
  localparam int CTRL_LEN_W   = 12;
  localparam int CTRL_MEM_LSB = 12;
  localparam int CTRL_MEM_W   = 3;
  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_STREAM = 2'd1,
    TX_DRAIN  = 2'd2
  } tx_state_t;
endpackage

// File: rtl/ram_stream_tx_skid_fifo.sv
// axis_skid_fifo: 2-entry fall-through FIFO; push/din in, pop/dout/valid/count out, async active-low reset
module axis_skid_fifo #(
  parameter int W = 65
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp, do_pop, store, take;
  assign valid  = (count != 2'd0) || push;
  // when empty, incoming data is presented directly so a read becomes visible one cycle later
  assign dout   = (count != 2'd0) ? mem[rp] : (push ? din : '0);
  assign do_pop = pop && valid;
  assign store  = push && !(count == 2'd0 && do_pop);
  assign take   = do_pop && (count != 2'd0);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= 2'd0;
      wp    <= 1'b0;
      rp    <= 1'b0;
    end else begin
      count <= count + {1'b0, store} - {1'b0, take};
      if (store) wp <= ~wp;
      if (take) rp <= ~rp;
    end
  end
  always_ff @(posedge CLK) begin
    if (store) mem[wp] <= din;
  end
endmodule

// File: rtl/ram_stream_tx.sv
// ram_stream_tx: streams a RAM region out on M_AXIS; ctrl_word/ctrl_start in, busy/done, RAM read port, M_AXIS master
module ram_stream_tx
  import ram_stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 12,
  parameter int MEM_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [31:0]           ctrl_word,
  input  logic                  ctrl_start,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [LEN_WIDTH-1:0]  ram_reg_adr,
  output logic [MEM_WIDTH-1:0]  ram_mem_adr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST
);
  tx_state_t state, state_n;
  logic [LEN_WIDTH-1:0] len_q, rd_adr, start_len;
  logic inflight, inflight_last, accept, rd_last, last_hs;
  logic [1:0] fifo_count;
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_word[31:CTRL_MEM_LSB+MEM_WIDTH];
  assign start_len   = ctrl_word[CTRL_LEN_LSB +: LEN_WIDTH];
  assign accept      = (state == TX_IDLE) && ctrl_start;
  assign rd_last     = rd_adr == len_q - LEN_WIDTH'(1);
  // credit check: FIFO entries plus the read still in the RAM pipeline never exceed 2
  assign ram_rd_en   = (state == TX_STREAM) && (({1'b0, fifo_count} + {2'b0, inflight}) < 3'd2);
  assign ram_reg_adr = rd_adr;
  assign busy        = state != TX_IDLE;
  assign last_hs     = M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;
  always_comb begin
    state_n = state;
    case (state)
      TX_IDLE:   state_n = (accept && start_len != '0) ? TX_STREAM : TX_IDLE;
      TX_STREAM: state_n = (ram_rd_en && rd_last) ? TX_DRAIN : TX_STREAM;
      TX_DRAIN:  state_n = last_hs ? TX_IDLE : TX_DRAIN;
      default:   state_n = TX_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= TX_IDLE;
      done          <= 1'b0;
      len_q         <= '0;
      rd_adr        <= '0;
      ram_mem_adr   <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_n;
      done          <= (accept && start_len == '0) || (state == TX_DRAIN && last_hs);
      inflight      <= ram_rd_en;
      inflight_last <= ram_rd_en && rd_last;
      if (accept) begin
        len_q       <= start_len;
        ram_mem_adr <= ctrl_word[CTRL_MEM_LSB +: MEM_WIDTH];
        rd_adr      <= '0;
      end else if (ram_rd_en && !rd_last) begin
        rd_adr <= rd_adr + LEN_WIDTH'(1);
      end
    end
  end
  axis_skid_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (inflight),
    .din   ({inflight_last, ram_dout}),
    .pop   (M_AXIS_TREADY),
    .dout  ({M_AXIS_TLAST, M_AXIS_TDATA}),
    .valid (M_AXIS_TVALID),
    .count (fifo_count)
  );
endmodule
